// File: rtl/nibble_serial_cmp.sv
// Serial magnitude comparator: walks two operands one nibble per beat and produces a
// 74HC85-compatible A>B / A<B / A=B result, seeded from a lower-order cascade stage.
module nibble_serial_cmp #(
  parameter int MAX_NIBBLES = 16,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic       IN_LAST,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       IAGB,
  input  logic       IASB,
  input  logic       IAEB,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       QAGB,
  output logic       QASB,
  output logic       QAEB,
  output logic       OVF
);

  localparam int CNT_W = (MAX_NIBBLES < 1) ? 1 : $clog2(MAX_NIBBLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_NIBBLES);

  typedef enum logic {ACC, HOLD} state_t;

  state_t           state, state_nxt;
  logic             armed;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       run, run_nxt;
  logic             resolved, resolved_nxt;
  logic             ovf, ovf_nxt;
  logic             accept, first, full;
  logic [2:0]       base;
  logic             base_resolved;

  // Cascade seed mapped to {gt, lt, eq} output form; IAEB dominates, otherwise
  // each output is the inverse of the opposite seed bit.
  function automatic logic [2:0] seed_decode(input logic gt, input logic lt, input logic eq);
    if (eq)
      return 3'b001;
    return {~lt, ~gt, 1'b0};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state    <= ACC;
      armed    <= 1'b0;
      cnt      <= '0;
      run      <= 3'b001;
      resolved <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      armed    <= 1'b1;
      cnt      <= cnt_nxt;
      run      <= run_nxt;
      resolved <= resolved_nxt;
      ovf      <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    run_nxt       = run;
    resolved_nxt  = resolved;
    ovf_nxt       = ovf;
    IN_READY      = (state == ACC) && armed;
    OUT_VALID     = (state == HOLD);
    accept        = IN_VALID && IN_READY;
    first         = (cnt == '0);
    full          = (cnt == CNT_MAX);
    // The first beat of an operand starts from the seed rather than leftover state.
    base          = first ? seed_decode(IAGB, IASB, IAEB) : run;
    base_resolved = first ? 1'b0 : resolved;

    case (state)
      ACC: begin
        if (accept) begin
          cnt_nxt      = sat_inc(cnt);
          run_nxt      = base;
          resolved_nxt = base_resolved;
          if (full) begin
            ovf_nxt = 1'b1;
          end else if ((A != B) && !(MSB_FIRST && base_resolved)) begin
            run_nxt      = (A > B) ? 3'b100 : 3'b010;
            resolved_nxt = 1'b1;
          end
          if (IN_LAST)
            state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (OUT_READY) begin
          state_nxt    = ACC;
          cnt_nxt      = '0;
          ovf_nxt      = 1'b0;
          resolved_nxt = 1'b0;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  assign QAGB = run[2];
  assign QASB = run[1];
  assign QAEB = run[0];
  assign OVF  = ovf;

endmodule

// File: tb/tb_nibble_serial_cmp.sv
// Directed bench: three comparator builds (LSB-first, MSB-first, LSB-first with
// MAX_NIBBLES=2) share one stimulus stream; each scenario task checks its own results.
module tb_nibble_serial_cmp;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [3:0] a_in = 4'h0;
  logic [3:0] b_in = 4'h0;
  logic       iagb = 1'b0;
  logic       iasb = 1'b0;
  logic       iaeb = 1'b1;
  logic       out_ready = 1'b0;

  logic       rdy0, rdy1, rdy2;
  logic       vld0, vld1, vld2;
  logic [2:0] q0, q1, q2;
  logic       ovf0, ovf1, ovf2;

  int tests = 0;
  int fails = 0;

  wire [4:0] obs0 = {vld0, q0, ovf0};
  wire [4:0] obs1 = {vld1, q1, ovf1};
  wire [4:0] obs2 = {vld2, q2, ovf2};

  always #5 clk = ~clk;

  nibble_serial_cmp #(.MAX_NIBBLES(16), .MSB_FIRST(1'b0)) dut0 (
    .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid), .IN_READY(rdy0), .IN_LAST(in_last),
    .A(a_in), .B(b_in), .IAGB(iagb), .IASB(iasb), .IAEB(iaeb),
    .OUT_VALID(vld0), .OUT_READY(out_ready),
    .QAGB(q0[2]), .QASB(q0[1]), .QAEB(q0[0]), .OVF(ovf0));

  nibble_serial_cmp #(.MAX_NIBBLES(16), .MSB_FIRST(1'b1)) dut1 (
    .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid), .IN_READY(rdy1), .IN_LAST(in_last),
    .A(a_in), .B(b_in), .IAGB(iagb), .IASB(iasb), .IAEB(iaeb),
    .OUT_VALID(vld1), .OUT_READY(out_ready),
    .QAGB(q1[2]), .QASB(q1[1]), .QAEB(q1[0]), .OVF(ovf1));

  nibble_serial_cmp #(.MAX_NIBBLES(2), .MSB_FIRST(1'b0)) dut2 (
    .CLK(clk), .RSTN(rstn), .IN_VALID(in_valid), .IN_READY(rdy2), .IN_LAST(in_last),
    .A(a_in), .B(b_in), .IAGB(iagb), .IASB(iasb), .IAEB(iaeb),
    .OUT_VALID(vld2), .OUT_READY(out_ready),
    .QAGB(q2[2]), .QASB(q2[1]), .QAEB(q2[0]), .OVF(ovf2));

  // Presents one beat at a negedge once the block is ready; returns at the negedge
  // after the accepting edge.
  task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic last);
    int n = 0;
    @(negedge clk);
    while (!rdy0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy0) begin
      tests++; fails++;
      $display("FAIL beat_ready_timeout got IN_READY=%b want 1", rdy0);
    end
    in_valid = 1'b1; a_in = a; b_in = b; in_last = last;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if ({rdy0, vld0} !== 2'b10) begin
      fails++;
      $display("FAIL consume_ready got rdy/vld=%b want 10", {rdy0, vld0});
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({obs0, obs1, obs2} !== {3{5'b0_001_0}}) begin
      fails++;
      $display("FAIL reset_outputs got %b want %b", {obs0, obs1, obs2}, {3{5'b0_001_0}});
    end
    tests++;
    if ({rdy0, rdy1, rdy2} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ready_low got %b want 000", {rdy0, rdy1, rdy2});
    end
    rstn = 1'b1;
    @(negedge clk);
    tests++;
    if ({rdy0, rdy1, rdy2} !== 3'b111) begin
      fails++;
      $display("FAIL reset_ready_rise got %b want 111", {rdy0, rdy1, rdy2});
    end
  endtask

  task automatic test_lsb_first();
    {iagb, iasb, iaeb} = 3'b001;
    beat(4'h3, 4'h5, 1'b0);
    beat(4'h9, 4'h9, 1'b0);
    @(negedge clk);
    tests++;
    if (vld0 !== 1'b0) begin
      fails++;
      $display("FAIL lsb_valid_early got %b want 0", vld0);
    end
    in_valid = 1'b1; a_in = 4'h7; b_in = 4'h2; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    tests++;
    if (obs0 !== 5'b1_100_0) begin
      fails++;
      $display("FAIL lsb_dut0 got %b want %b", obs0, 5'b1_100_0);
    end
    tests++;
    if (obs1 !== 5'b1_010_0) begin
      fails++;
      $display("FAIL lsb_dut1_msb got %b want %b", obs1, 5'b1_010_0);
    end
    tests++;
    if (obs2 !== 5'b1_010_1) begin
      fails++;
      $display("FAIL lsb_dut2_max2 got %b want %b", obs2, 5'b1_010_1);
    end
    consume();
  endtask

  task automatic test_msb_first();
    {iagb, iasb, iaeb} = 3'b001;
    beat(4'h4, 4'h4, 1'b0);
    beat(4'h2, 4'h8, 1'b0);
    beat(4'hF, 4'h0, 1'b1);
    tests++;
    if (obs1 !== 5'b1_010_0) begin
      fails++;
      $display("FAIL msb_dut1 got %b want %b", obs1, 5'b1_010_0);
    end
    tests++;
    if (obs0 !== 5'b1_100_0) begin
      fails++;
      $display("FAIL msb_dut0_lsb got %b want %b", obs0, 5'b1_100_0);
    end
    tests++;
    if (obs2 !== 5'b1_010_1) begin
      fails++;
      $display("FAIL msb_dut2_max2 got %b want %b", obs2, 5'b1_010_1);
    end
    consume();
  endtask

  task automatic test_seed_table();
    logic [2:0] seeds [6] = '{3'b001, 3'b100, 3'b010, 3'b000, 3'b110, 3'b111};
    logic [2:0] exps  [6] = '{3'b001, 3'b100, 3'b010, 3'b110, 3'b000, 3'b001};
    for (int i = 0; i < 6; i++) begin
      {iagb, iasb, iaeb} = seeds[i];
      beat(4'h6, 4'h6, 1'b1);
      tests++;
      if ({obs0, obs1, obs2} !== {3{1'b1, exps[i], 1'b0}}) begin
        fails++;
        $display("FAIL seed_%b got %b want %b", seeds[i], {obs0, obs1, obs2},
                 {3{1'b1, exps[i], 1'b0}});
      end
      consume();
    end
  endtask

  task automatic test_seed_latch();
    {iagb, iasb, iaeb} = 3'b001;
    beat(4'h5, 4'h5, 1'b0);
    {iagb, iasb, iaeb} = 3'b100;
    beat(4'h5, 4'h5, 1'b1);
    tests++;
    if ({obs0, obs1, obs2} !== {3{5'b1_001_0}}) begin
      fails++;
      $display("FAIL seed_latch got %b want %b", {obs0, obs1, obs2}, {3{5'b1_001_0}});
    end
    consume();
  endtask

  task automatic test_overflow();
    {iagb, iasb, iaeb} = 3'b001;
    beat(4'h1, 4'h0, 1'b0);
    beat(4'h0, 4'h0, 1'b0);
    beat(4'h0, 4'h9, 1'b1);
    tests++;
    if (obs2 !== 5'b1_100_1) begin
      fails++;
      $display("FAIL ovf_dut2 got %b want %b", obs2, 5'b1_100_1);
    end
    tests++;
    if (obs0 !== 5'b1_010_0) begin
      fails++;
      $display("FAIL ovf_dut0 got %b want %b", obs0, 5'b1_010_0);
    end
    tests++;
    if (obs1 !== 5'b1_100_0) begin
      fails++;
      $display("FAIL ovf_dut1 got %b want %b", obs1, 5'b1_100_0);
    end
    consume();
    beat(4'h8, 4'h3, 1'b1);
    tests++;
    if ({obs0, obs1, obs2} !== {3{5'b1_100_0}}) begin
      fails++;
      $display("FAIL ovf_cleared got %b want %b", {obs0, obs1, obs2}, {3{5'b1_100_0}});
    end
    consume();
  endtask

  task automatic test_hold();
    {iagb, iasb, iaeb} = 3'b001;
    beat(4'hA, 4'h3, 1'b0);
    beat(4'h1, 4'h1, 1'b1);
    in_valid = 1'b1; a_in = 4'h0; b_in = 4'hF; in_last = 1'b1;
    {iagb, iasb, iaeb} = 3'b010;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({rdy0, obs0, obs1, obs2} !== {1'b0, {3{5'b1_100_0}}}) begin
        fails++;
        $display("FAIL hold_cycle%0d got %b want %b", i, {rdy0, obs0, obs1, obs2},
                 {1'b0, {3{5'b1_100_0}}});
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    consume();
  endtask

  task automatic test_reset_mid();
    {iagb, iasb, iaeb} = 3'b100;
    beat(4'h0, 4'h0, 1'b0);
    beat(4'h5, 4'h1, 1'b0);
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if ({rdy0, obs0, obs1, obs2} !== {1'b0, {3{5'b0_001_0}}}) begin
        fails++;
        $display("FAIL rst_mid_%0d got %b want %b", i, {rdy0, obs0, obs1, obs2},
                 {1'b0, {3{5'b0_001_0}}});
      end
    end
    rstn = 1'b1;
    {iagb, iasb, iaeb} = 3'b010;
    beat(4'h2, 4'h2, 1'b1);
    tests++;
    if ({obs0, obs1, obs2} !== {3{5'b1_010_0}}) begin
      fails++;
      $display("FAIL rst_mid_fresh got %b want %b", {obs0, obs1, obs2}, {3{5'b1_010_0}});
    end
    rstn = 1'b0;
    @(negedge clk);
    tests++;
    if ({rdy0, obs0} !== {1'b0, 5'b0_001_0}) begin
      fails++;
      $display("FAIL rst_hold got %b want %b", {rdy0, obs0}, {1'b0, 5'b0_001_0});
    end
    rstn = 1'b1;
    @(negedge clk);
    tests++;
    if ({rdy0, vld0} !== 2'b10) begin
      fails++;
      $display("FAIL rst_hold_release got %b want 10", {rdy0, vld0});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_seed_table();
    test_seed_latch();
    test_overflow();
    test_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
